// File: rtl/io_stream_pkg.sv
// Shared constants and helpers for the fabric IO output stream.
// Widths here are defaults; instances may override DATA_WIDTH and DEPTH.
package io_stream_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  // Occupancy must represent 0..depth inclusive, hence depth+1.
  function automatic int countWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy and show-ahead read port.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo import io_stream_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 4,
  localparam int CNT_W     = countWidth(DEPTH),
  localparam int PTR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_wrData,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_rdData,
  output logic [CNT_W-1:0]      o_count,
  output logic                  o_full,
  output logic                  o_empty
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wrPtr;
  logic [PTR_W-1:0]      r_rdPtr;
  logic [CNT_W-1:0]      r_count;
  logic                  w_doPush;
  logic                  w_doPop;

  assign o_full   = (r_count == CNT_W'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;
  assign o_count  = r_count;
  assign o_rdData = r_mem[r_rdPtr];

  // Storage carries no reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_wrData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/io_out_stream.sv
// Captures fabric IO output words into a FIFO and presents them as a
// valid/ready stream, with backpressure, sticky overflow and occupancy.
module io_out_stream import io_stream_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 4,
  localparam int CNT_W     = countWidth(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] from_io,
  input  logic                  from_io_valid,
  output logic                  to_io_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_W-1:0]      count,
  output logic                  overflow,
  input  logic                  clear_overflow
);

  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_overflowEvent;
  logic [DATA_WIDTH-1:0] w_headData;
  logic                  r_overflow;

  // Ready depends only on registered occupancy, never on m_ready, so a
  // word offered at full is dropped even if the host pops that cycle.
  assign to_io_ready     = !rst && !w_full;
  assign w_push          = from_io_valid && to_io_ready;
  assign m_valid         = !w_empty;
  assign w_pop           = m_valid && m_ready;
  assign m_data          = m_valid ? w_headData : '0;
  assign w_overflowEvent = from_io_valid && !to_io_ready;
  assign overflow        = r_overflow;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_push   (w_push),
    .i_wrData (from_io),
    .i_pop    (w_pop),
    .o_rdData (w_headData),
    .o_count  (count),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  // A fresh overflow event beats a simultaneous clear request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_overflowEvent) begin
      r_overflow <= 1'b1;
    end else if (clear_overflow) begin
      r_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_io_out_stream.sv
// Randomized and directed bench for io_out_stream against a queue-based
// reference model of the FIFO stream and its sticky overflow flag.
module tb_io_out_stream;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] from_io = '0;
  logic          from_io_valid = 1'b0;
  logic          to_io_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [CW-1:0] count;
  logic          overflow;
  logic          clear_overflow = 1'b0;

  int testCount = 0;
  int failCount = 0;

  logic [DW-1:0] modelQ[$];
  logic          modelOvf = 1'b0;

  io_out_stream #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .from_io        (from_io),
    .from_io_valid  (from_io_valid),
    .to_io_ready    (to_io_ready),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .count          (count),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkModel();
    logic [DW-1:0] head;
    head = (modelQ.size() != 0) ? modelQ[0] : '0;
    checkOutput("count", 64'(count), 64'(modelQ.size()));
    checkOutput("m_valid", 64'(m_valid), 64'(modelQ.size() != 0));
    checkOutput("m_data", 64'(m_data), 64'(head));
    checkOutput("to_io_ready", 64'(to_io_ready), 64'(modelQ.size() != DEPTH));
    checkOutput("overflow", 64'(overflow), 64'(modelOvf));
  endtask

  // Called at a falling edge: check current state, drive one cycle of
  // inputs, advance the model across the rising edge.
  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic r, input logic c);
    bit full, doPop, doPush;
    checkModel();
    from_io_valid  = v;
    from_io        = d;
    m_ready        = r;
    clear_overflow = c;
    full   = (modelQ.size() == DEPTH);
    doPop  = (modelQ.size() != 0) && r;
    doPush = v && !full;
    @(posedge clk);
    if (doPop) void'(modelQ.pop_front());
    if (doPush) modelQ.push_back(d);
    if (v && full) modelOvf = 1'b1;
    else if (c) modelOvf = 1'b0;
    @(negedge clk);
  endtask

  task automatic doReset();
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_m_valid", 64'(m_valid), 64'd0);
    checkOutput("rst_count", 64'(count), 64'd0);
    checkOutput("rst_m_data", 64'(m_data), 64'd0);
    checkOutput("rst_ready", 64'(to_io_ready), 64'd0);
    checkOutput("rst_overflow", 64'(overflow), 64'd0);
    modelQ.delete();
    modelOvf = 1'b0;
    from_io_valid  = 1'b0;
    m_ready        = 1'b0;
    clear_overflow = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_ready", 64'(to_io_ready), 64'd1);
  endtask

  initial begin
    @(negedge clk);
    doReset();

    // Single word, held then popped
    applyStimulus(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    checkOutput("single_data", 64'(m_data), 64'hDEADBEEF);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("single_drained", 64'(m_valid), 64'd0);

    // Fill, overflow, drain
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 32'(i), 1'b0, 1'b0);
    checkOutput("fill_ready", 64'(to_io_ready), 64'd0);
    applyStimulus(1'b1, 32'h5, 1'b0, 1'b0);
    checkOutput("fill_overflow", 64'(overflow), 64'd1);
    for (int i = 1; i <= 4; i++) begin
      checkOutput("drain_order", 64'(m_data), 64'(i));
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);

    // Push+pop at full: offer rejected, then accepted next cycle
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h9, 1'b1, 1'b0);
    checkOutput("full_pop_count", 64'(count), 64'd3);
    checkOutput("full_pop_ovf", 64'(overflow), 64'd1);
    applyStimulus(1'b1, 32'h9, 1'b0, 1'b0);
    checkOutput("full_retry_count", 64'(count), 64'd4);

    // Clear priority: event and clear together keeps the flag
    applyStimulus(1'b1, 32'hA, 1'b0, 1'b1);
    checkOutput("clr_vs_event", 64'(overflow), 64'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("clr_alone", 64'(overflow), 64'd0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // Wrap-around streaming
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 32'(i), 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("stream_ovf", 64'(overflow), 64'd0);

    // Randomized traffic with a mid-run reset while data is buffered
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, $urandom, 1'b0, 1'b0);
        doReset();
      end
      applyStimulus(($urandom_range(0, 9) < 6), $urandom,
                    ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) == 0));
    end
    checkModel();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/io_out_stream.md
Name: io_out_stream

Overview:
Receiving end of the fabric IO output path. Captures 32-bit words that the fabric drives on an IO tile's output bus, qualified by a fabric valid bit, and buffers them in a small FIFO. Presents them to the host/testbench side as a valid/ready stream. Provides backpressure to the fabric, a sticky overflow flag and an occupancy count.

Parameters:
- DATA_WIDTH, 32, width of fabric IO word and host stream data
- DEPTH, 4, FIFO entries; power of two, >= 2
- CNT_W, $clog2(DEPTH+1), width of occupancy count (derived, not overridden)

Ports:
- clk  input  1  single clock; all state on rising edge
- rst  input  1  reset, asynchronous, active-high; everything clears immediately on assertion
- from_io  input  DATA_WIDTH  word driven by fabric IO tile output
- from_io_valid  input  1  fabric qualifies from_io this cycle
- to_io_ready  output  1  backpressure to fabric: 1 = a word offered this cycle is accepted
- m_data  output  DATA_WIDTH  head-of-FIFO word to host
- m_valid  output  1  m_data holds a valid word
- m_ready  input  1  host accepts m_data this cycle
- count  output  CNT_W  words currently stored (0..DEPTH)
- overflow  output  1  sticky: a valid word was offered while to_io_ready = 0
- clear_overflow  input  1  synchronous clear of overflow

Behaviour:
- Reset (async, active-high): wr_ptr = rd_ptr = 0, count = 0, m_valid = 0, m_data = 0, overflow = 0, to_io_ready = 0 while rst is high; to_io_ready = 1 from the first cycle after release. Storage contents are don't-care.
- to_io_ready = !rst && (count != DEPTH). It is derived from registered count only, with no combinational path from m_ready.
- push = from_io_valid && to_io_ready. On push, from_io is written at wr_ptr and wr_ptr increments modulo DEPTH (natural wrap).
- pop = m_valid && m_ready. On pop, rd_ptr increments modulo DEPTH.
- count_next = count + push - pop. Push and pop in the same cycle leave count unchanged.
- Full (count = DEPTH): to_io_ready = 0. An offered word is dropped even if pop happens in the same cycle; the freed slot is usable next cycle.
- Empty (count = 0): m_valid = 0. A push makes m_valid = 1 on the next edge. Latency from fabric to host is 1 cycle, with no bypass.
- m_data is show-ahead: storage[rd_ptr], valid whenever m_valid = 1. It stays stable while m_valid && !m_ready.
- m_valid = (count != 0), registered via count.
- overflow sets on any cycle with from_io_valid && !to_io_ready && !rst. It clears on clear_overflow when no new overflow event occurs that cycle; set wins over clear.
- Word order is strict FIFO, with no reordering or duplication.
- Reset mid-operation: all buffered words are discarded, and m_valid falls asynchronously.

Decomposition:
- Shared package io_stream_pkg: DATA_WIDTH default constant and a count-width function (clog2 of DEPTH+1).
- Sub-module sync_fifo (parameters DATA_WIDTH, DEPTH): storage, pointers, count, full/empty.
- Top io_out_stream: fabric-side handshake, overflow sticky logic, output mapping.

Test Plan:
- Reset/idle: assert rst mid-clock, then release -> m_valid = 0, count = 0, overflow = 0, m_data = 0; to_io_ready = 1 on the first cycle after release.
- Single word: from_io = 0xDEADBEEF with valid for 1 cycle, m_ready = 0 -> next cycle m_valid = 1, m_data = 0xDEADBEEF, count = 1. Then m_ready = 1 for 1 cycle -> count = 0, m_valid = 0.
- Fill and overflow: push 0x1, 0x2, 0x3, 0x4 with m_ready = 0, then offer 0x5 -> to_io_ready = 0 after the 4th word, 0x5 dropped, overflow = 1. Drain yields 1, 2, 3, 4 only.
- Simultaneous push/pop at full: count = 4, m_ready = 1 and valid 0x9 in the same cycle -> 0x9 rejected, overflow sets, count = 3. Next cycle 0x9 is accepted.
- Wrap-around streaming: 20 consecutive words 0..19 with m_ready = 1 -> all received in order, count stays <= 1, overflow = 0.
- Overflow clear priority: clear_overflow = 1 in the same cycle as a new overflow event -> overflow stays 1. A later clear with no event -> overflow = 0.
